pcb_read_arbiter: RTL and testbench
===================================

Name: pcb_read_arbiter

Overview:
- Shares the single packet-centralized-buffer (PCB) read-address port among PORT_NUM network transmit engines.
- Each engine issues one 16-bit line address per request. The block grants requests round-robin and forwards the granted request to the PCB.
- It records the granted port in a tag FIFO and steers each returned 134-bit data word to the requester that owns it.
- It sits between the per-port network_tx instances and the PCB read interface.

Parameters:
- PORT_NUM, 4, number of requesting transmit ports (2..8).
- PORT_W, 2, width of a port index; equals clog2(PORT_NUM).
- TAG_DEPTH, 8, number of outstanding reads (power of two, ≥ PCB read latency + 2).
- TAG_AW, 3, tag FIFO address width; equals clog2(TAG_DEPTH).

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- iv_pkt_raddr  in  PORT_NUM*16  per-port read line address; port k occupies bits [16k+15:16k]
- iv_pkt_rd  in  PORT_NUM  per-port read request; held until acked
- ov_pkt_raddr_ack  out  PORT_NUM  one-cycle ack to the granted port
- ov_pkt_raddr  out  16  address to PCB
- o_pkt_rd  out  1  read request to PCB; held until i_pkt_raddr_ack
- i_pkt_raddr_ack  in  1  PCB accepts address
- iv_pkt_data  in  134  PCB read data
- i_pkt_data_wr  in  1  PCB read data valid
- ov_pkt_data  out  134  registered data broadcast to all ports
- ov_pkt_data_wr  out  PORT_NUM  one-hot data valid for the owning port
- o_tag_underflow_error_pulse  out  1  data arrived with no outstanding tag
- ov_outstanding  out  TAG_AW+1  current tag FIFO occupancy

Behaviour:
- Reset (i_rst sampled high on a rising edge):
  - All outputs go to 0.
  - The round-robin pointer goes to port 0, the FSM goes to IDLE, and the tag FIFO is emptied.
  - A read in flight at reset is abandoned. PCB data arriving after reset produces an underflow pulse and is dropped.
- FSM IDLE:
  - When any iv_pkt_rd bit is set and the tag FIFO is not full, select the first requesting port at or after rr_ptr (cyclic).
  - Register its address into ov_pkt_raddr and the port into grant_id, set o_pkt_rd, and go to WAIT_ACK.
  - Request-to-o_pkt_rd latency is 1 cycle.
- FSM WAIT_ACK:
  - o_pkt_rd and ov_pkt_raddr stay stable.
  - On i_pkt_raddr_ack:
    - clear o_pkt_rd;
    - pulse ov_pkt_raddr_ack[grant_id] for exactly 1 cycle (the same cycle o_pkt_rd falls);
    - push grant_id into the tag FIFO;
    - set rr_ptr = grant_id+1, wrapping at PORT_NUM-1 to 0;
    - return to IDLE.
  - At most one grant per 2 cycles; a new request is evaluated on the cycle after returning to IDLE.
- Requester rule: a port must not drop iv_pkt_rd or change its address before its ack. Dropping it while granted does not cancel the PCB read; the data is still delivered.
- Data return:
  - On i_pkt_data_wr with the FIFO non-empty, pop the head tag.
  - Next cycle: ov_pkt_data = iv_pkt_data, and ov_pkt_data_wr is one-hot at the tag. Latency is 1 cycle.
  - With the FIFO empty: no pop, ov_pkt_data_wr = 0, and o_tag_underflow_error_pulse is high for 1 cycle.
- Simultaneous push (ack) and pop (data_wr) in the same cycle: both occur and occupancy is unchanged. Push into a FIFO that is empty in that cycle is legal: data_wr pops the old head only if occupancy > 0; otherwise underflow.
- Full: with occupancy == TAG_DEPTH, no new grant is issued. WAIT_ACK is never entered when full, so a push never overflows.
- Pointers are TAG_AW bits and wrap naturally. Occupancy is TAG_AW+1 bits and is driven on ov_outstanding.
- Data ordering equals ack ordering; the PCB returns reads in order.

Decomposition:
- Shared package holds:
  - DATA_W = 134 and RADDR_W = 16;
  - FSM state encoding: IDLE = 1'b0, WAIT_ACK = 1'b1.
- One natural sub-module: rr_tag_fifo, a synchronous FIFO of PORT_W-bit tags with full, empty and occupancy outputs, depth TAG_DEPTH.
- The round-robin priority-select is implemented inline.

Test Plan:
1. Single port: port 2 raises rd with addr 0x0123. Expect o_pkt_rd next cycle with addr 0x0123. Ack after 3 cycles gives ov_pkt_raddr_ack = 4'b0100 for 1 cycle. PCB data 0xA5.. with data_wr gives ov_pkt_data_wr = 4'b0100 one cycle later.
2. Fairness: all 4 ports request continuously, PCB acks immediately. Grant order 0,1,2,3,0,1 and no port acked twice within 4 grants.
3. Full: PCB acks 8 reads without returning data. Ninth request is not forwarded and ov_outstanding = 8. One data_wr gives the next grant in the following IDLE cycle.
4. Simultaneous: ack for port 1 in the same cycle as data_wr for an outstanding port-3 tag. Data goes to port 3 and occupancy stays unchanged.
5. Underflow: data_wr with empty FIFO gives o_tag_underflow_error_pulse = 1 for 1 cycle and ov_pkt_data_wr = 0.
6. Reset mid-read: i_rst while in WAIT_ACK with 3 tags outstanding. All outputs 0 and ov_outstanding = 0. Later stale data_wr gives an underflow pulse, and the next request is granted starting from port 0.

Source files
------------

// File: rtl/pcb_read_arbiter_pkg.sv
// Shared widths and FSM encoding for the PCB read-address arbiter slice.
package pcb_read_arbiter_pkg;

    localparam int unsigned DATA_W  = 134;
    localparam int unsigned RADDR_W = 16;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/pcb_read_arbiter_if.sv
// Bus bundle between the transmit engines / PCB side and the read arbiter.
interface pcb_read_arbiter_if #(
    parameter int unsigned PORT_NUM = 4,
    parameter int unsigned TAG_AW   = 3
);
    import pcb_read_arbiter_pkg::*;

    logic [PORT_NUM*RADDR_W-1:0] iv_pkt_raddr;
    logic [PORT_NUM-1:0]         iv_pkt_rd;
    logic [PORT_NUM-1:0]         ov_pkt_raddr_ack;
    logic [RADDR_W-1:0]          ov_pkt_raddr;
    logic                        o_pkt_rd;
    logic                        i_pkt_raddr_ack;
    logic [DATA_W-1:0]           iv_pkt_data;
    logic                        i_pkt_data_wr;
    logic [DATA_W-1:0]           ov_pkt_data;
    logic [PORT_NUM-1:0]         ov_pkt_data_wr;
    logic                        o_tag_underflow_error_pulse;
    logic [TAG_AW:0]             ov_outstanding;

    modport slave (
        input  iv_pkt_raddr, iv_pkt_rd, i_pkt_raddr_ack, iv_pkt_data, i_pkt_data_wr,
        output ov_pkt_raddr_ack, ov_pkt_raddr, o_pkt_rd, ov_pkt_data, ov_pkt_data_wr,
               o_tag_underflow_error_pulse, ov_outstanding
    );

    modport master (
        output iv_pkt_raddr, iv_pkt_rd, i_pkt_raddr_ack, iv_pkt_data, i_pkt_data_wr,
        input  ov_pkt_raddr_ack, ov_pkt_raddr, o_pkt_rd, ov_pkt_data, ov_pkt_data_wr,
               o_tag_underflow_error_pulse, ov_outstanding
    );

endinterface

// File: rtl/pcb_read_arbiter_rr_tag_fifo.sv
// Synchronous FIFO of granted-port tags; one entry per outstanding PCB read.
module rr_tag_fifo #(
    parameter int unsigned TAG_W = 2,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [TAG_W-1:0] push_tag,
    input  logic             pop,
    output logic [TAG_W-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [TAG_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/pcb_read_arbiter.sv
// Round-robin sharing of the PCB read-address port among PORT_NUM transmit
// engines, with tag-FIFO steering of returned read data back to the owner.
module pcb_read_arbiter
    import pcb_read_arbiter_pkg::*;
#(
    parameter int unsigned PORT_NUM  = 4,
    parameter int unsigned PORT_W    = 2,
    parameter int unsigned TAG_DEPTH = 8,
    parameter int unsigned TAG_AW    = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    pcb_read_arbiter_if.slave  bus
);

    arb_state_e          state;
    logic [PORT_W-1:0]   rr_ptr;
    logic [PORT_W-1:0]   grant_id;
    logic [PORT_W-1:0]   sel_port;
    logic                sel_valid;
    int unsigned         cand;
    logic [RADDR_W-1:0]  port_addr [PORT_NUM];

    logic                fifo_push;
    logic                fifo_pop;
    logic [PORT_W-1:0]   fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic [TAG_AW:0]     fifo_count;

    for (genvar k = 0; k < PORT_NUM; k++) begin : g_addr
        assign port_addr[k] = bus.iv_pkt_raddr[k*RADDR_W +: RADDR_W];
    end

    // First requester at or after rr_ptr, scanning cyclically.
    always_comb begin
        sel_valid = 1'b0;
        sel_port  = '0;
        cand      = 0;
        for (int unsigned i = 0; i < PORT_NUM; i++) begin
            cand = 32'(rr_ptr) + i;
            if (cand >= PORT_NUM) cand = cand - PORT_NUM;
            if (!sel_valid && bus.iv_pkt_rd[PORT_W'(cand)]) begin
                sel_valid = 1'b1;
                sel_port  = PORT_W'(cand);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state                <= IDLE;
            rr_ptr               <= '0;
            grant_id             <= '0;
            bus.o_pkt_rd         <= 1'b0;
            bus.ov_pkt_raddr     <= '0;
            bus.ov_pkt_raddr_ack <= '0;
        end else begin
            bus.ov_pkt_raddr_ack <= '0;
            case (state)
                IDLE: begin
                    if (sel_valid && !fifo_full) begin
                        bus.ov_pkt_raddr <= port_addr[sel_port];
                        grant_id         <= sel_port;
                        bus.o_pkt_rd     <= 1'b1;
                        state            <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (bus.i_pkt_raddr_ack) begin
                        bus.o_pkt_rd         <= 1'b0;
                        bus.ov_pkt_raddr_ack <= PORT_NUM'(1) << grant_id;
                        rr_ptr               <= (32'(grant_id) == PORT_NUM - 1) ? '0
                                                : grant_id + PORT_W'(1);
                        state                <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign fifo_push = (state == WAIT_ACK) && bus.i_pkt_raddr_ack;
    assign fifo_pop  = bus.i_pkt_data_wr && !fifo_empty;

    rr_tag_fifo #(
        .TAG_W (PORT_W),
        .DEPTH (TAG_DEPTH),
        .AW    (TAG_AW)
    ) u_tag_fifo (
        .clk      (i_clk),
        .rst      (i_rst),
        .push     (fifo_push),
        .push_tag (grant_id),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign bus.ov_outstanding = fifo_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.ov_pkt_data                 <= '0;
            bus.ov_pkt_data_wr              <= '0;
            bus.o_tag_underflow_error_pulse <= 1'b0;
        end else begin
            if (bus.i_pkt_data_wr) bus.ov_pkt_data <= bus.iv_pkt_data;
            bus.ov_pkt_data_wr              <= fifo_pop ? (PORT_NUM'(1) << fifo_head) : '0;
            bus.o_tag_underflow_error_pulse <= bus.i_pkt_data_wr && fifo_empty;
        end
    end

endmodule

// File: tb/tb_pcb_read_arbiter.sv
// Scenario bench for pcb_read_arbiter: grant order, tag steering, full,
// underflow and reset behaviour checked against a bench-side tag scoreboard.
module tb_pcb_read_arbiter;

    typedef struct {
        logic [3:0]   wr;
        logic [133:0] data;
        logic         uf;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    exp_t exp_q[$];
    int   tag_q[$];
    logic [15:0] addr_tab [4] = '{16'h1A00, 16'h2B11, 16'h3C22, 16'h4D33};

    pcb_read_arbiter_if #(.PORT_NUM(4), .TAG_AW(3)) bus ();

    pcb_read_arbiter #(
        .PORT_NUM  (4),
        .PORT_W    (2),
        .TAG_DEPTH (8),
        .TAG_AW    (3)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [133:0] rand_data();
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return r[133:0];
    endfunction

    task automatic set_addrs();
        for (int p = 0; p < 4; p++) bus.iv_pkt_raddr[p*16 +: 16] = addr_tab[p];
    endtask

    // Drive one PCB data beat and record what the owning port should see.
    task automatic drive_data(input logic [133:0] d);
        exp_t e;
        int   p;
        bus.iv_pkt_data   = d;
        bus.i_pkt_data_wr = 1'b1;
        e.data = d;
        if (tag_q.size() > 0) begin
            p    = tag_q.pop_front();
            e.wr = 4'b0001 << p;
            e.uf = 1'b0;
        end else begin
            e.wr = 4'b0000;
            e.uf = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.iv_pkt_rd = '0; bus.i_pkt_raddr_ack = 1'b0; bus.i_pkt_data_wr = 1'b0;
        bus.iv_pkt_raddr = '0; bus.iv_pkt_data = '0;
        tick(); tick();
        rst = 1'b0;
        total++;
        if ({bus.o_pkt_rd, bus.ov_pkt_raddr_ack, bus.ov_pkt_data_wr, bus.o_tag_underflow_error_pulse,
             bus.ov_outstanding, bus.ov_pkt_raddr} !== 31'd0) begin
            bad++;
            $display("FAIL reset_ctrl: rd=%b ack=%b wr=%b uf=%b outst=%0d addr=%h want all zero",
                     bus.o_pkt_rd, bus.ov_pkt_raddr_ack, bus.ov_pkt_data_wr,
                     bus.o_tag_underflow_error_pulse, bus.ov_outstanding, bus.ov_pkt_raddr);
        end
        total++;
        if (bus.ov_pkt_data !== '0) begin
            bad++;
            $display("FAIL reset_data: got %h want 0", bus.ov_pkt_data);
        end
    endtask

    task automatic test_single_port();
        logic [135:0] pat;
        exp_t e;
        pat = {17{8'hA5}};
        bus.iv_pkt_raddr[2*16 +: 16] = 16'h0123;
        bus.iv_pkt_rd = 4'b0100;
        tick();
        total++;
        if (bus.o_pkt_rd !== 1'b1 || bus.ov_pkt_raddr !== 16'h0123) begin
            bad++;
            $display("FAIL t1_rd: rd=%b addr=%h want rd=1 addr=0123", bus.o_pkt_rd, bus.ov_pkt_raddr);
        end
        tick(); tick();
        total++;
        if (bus.o_pkt_rd !== 1'b1 || bus.ov_pkt_raddr !== 16'h0123 || bus.ov_pkt_raddr_ack !== 4'b0000) begin
            bad++;
            $display("FAIL t1_hold: rd=%b addr=%h ack=%b want 1/0123/0000",
                     bus.o_pkt_rd, bus.ov_pkt_raddr, bus.ov_pkt_raddr_ack);
        end
        bus.i_pkt_raddr_ack = 1'b1;
        tick();
        bus.i_pkt_raddr_ack = 1'b0;
        bus.iv_pkt_rd = '0;
        tag_q.push_back(2);
        total++;
        if (bus.ov_pkt_raddr_ack !== 4'b0100 || bus.o_pkt_rd !== 1'b0) begin
            bad++;
            $display("FAIL t1_ack: ack=%b rd=%b want 0100/0", bus.ov_pkt_raddr_ack, bus.o_pkt_rd);
        end
        tick();
        total++;
        if (bus.ov_pkt_raddr_ack !== 4'b0000 || bus.ov_outstanding !== 4'd1 || bus.o_pkt_rd !== 1'b0) begin
            bad++;
            $display("FAIL t1_ack_pulse: ack=%b outst=%0d rd=%b want 0000/1/0",
                     bus.ov_pkt_raddr_ack, bus.ov_outstanding, bus.o_pkt_rd);
        end
        drive_data(pat[133:0]);
        tick();
        bus.i_pkt_data_wr = 1'b0;
        e = exp_q.pop_front();
        total++;
        if (bus.ov_pkt_data_wr !== e.wr || bus.ov_pkt_data !== e.data || bus.o_tag_underflow_error_pulse !== e.uf) begin
            bad++;
            $display("FAIL t1_data: wr=%b uf=%b data=%h want wr=%b uf=%b data=%h",
                     bus.ov_pkt_data_wr, bus.o_tag_underflow_error_pulse, bus.ov_pkt_data, e.wr, e.uf, e.data);
        end
        tick();
        total++;
        if (bus.ov_pkt_data_wr !== 4'b0000 || bus.ov_outstanding !== 4'd0) begin
            bad++;
            $display("FAIL t1_data_pulse: wr=%b outst=%0d want 0000/0", bus.ov_pkt_data_wr, bus.ov_outstanding);
        end
    endtask

    // Return data for every outstanding tag on consecutive cycles.
    task automatic test_drain(input string name);
        exp_t e;
        int   n;
        n = tag_q.size();
        if (n > 0) drive_data(rand_data());
        for (int i = 0; i < n; i++) begin
            tick();
            e = exp_q.pop_front();
            total++;
            if (bus.ov_pkt_data_wr !== e.wr || bus.ov_pkt_data !== e.data || bus.o_tag_underflow_error_pulse !== e.uf) begin
                bad++;
                $display("FAIL %s_drain[%0d]: wr=%b uf=%b data=%h want wr=%b uf=%b data=%h", name, i,
                         bus.ov_pkt_data_wr, bus.o_tag_underflow_error_pulse, bus.ov_pkt_data, e.wr, e.uf, e.data);
            end
            if (i + 1 < n) drive_data(rand_data());
            else bus.i_pkt_data_wr = 1'b0;
        end
        tick();
        total++;
        if (bus.ov_outstanding !== 4'd0 || bus.ov_pkt_data_wr !== 4'b0000) begin
            bad++;
            $display("FAIL %s_drained: outst=%0d wr=%b want 0/0000", name, bus.ov_outstanding, bus.ov_pkt_data_wr);
        end
    endtask

    task automatic test_fairness();
        int n;
        int p;
        rst = 1'b1; tick(); rst = 1'b0;
        set_addrs();
        bus.iv_pkt_rd = 4'b1111;
        bus.i_pkt_raddr_ack = 1'b1;
        n = 0;
        for (int c = 0; c < 60 && n < 6; c++) begin
            tick();
            p = n % 4;
            if (bus.o_pkt_rd === 1'b1) begin
                total++;
                if (bus.ov_pkt_raddr !== addr_tab[p]) begin
                    bad++;
                    $display("FAIL t2_addr[%0d]: got %h want %h", n, bus.ov_pkt_raddr, addr_tab[p]);
                end
            end
            if (bus.ov_pkt_raddr_ack !== 4'b0000) begin
                total++;
                if (bus.ov_pkt_raddr_ack !== (4'b0001 << p)) begin
                    bad++;
                    $display("FAIL t2_grant[%0d]: ack=%b want %b", n, bus.ov_pkt_raddr_ack, 4'b0001 << p);
                end
                tag_q.push_back(p);
                n++;
            end
        end
        bus.i_pkt_raddr_ack = 1'b0;
        bus.iv_pkt_rd = '0;
        total++;
        if (n != 6 || bus.ov_outstanding !== 4'd6) begin
            bad++;
            $display("FAIL t2_count: grants=%0d outst=%0d want 6/6", n, bus.ov_outstanding);
        end
        test_drain("t2");
    endtask

    task automatic test_full();
        exp_t e;
        int   p;
        bus.iv_pkt_rd = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            p = (2 + k) % 4;
            for (int c = 0; c < 10 && bus.o_pkt_rd !== 1'b1; c++) tick();
            total++;
            if (bus.o_pkt_rd !== 1'b1 || bus.ov_pkt_raddr !== addr_tab[p]) begin
                bad++;
                $display("FAIL t3_grant[%0d]: rd=%b addr=%h want 1/%h", k, bus.o_pkt_rd, bus.ov_pkt_raddr, addr_tab[p]);
            end
            bus.i_pkt_raddr_ack = 1'b1;
            tick();
            bus.i_pkt_raddr_ack = 1'b0;
            tag_q.push_back(p);
            total++;
            if (bus.ov_pkt_raddr_ack !== (4'b0001 << p)) begin
                bad++;
                $display("FAIL t3_ack[%0d]: ack=%b want %b", k, bus.ov_pkt_raddr_ack, 4'b0001 << p);
            end
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if (bus.o_pkt_rd !== 1'b0 || bus.ov_outstanding !== 4'd8) begin
                bad++;
                $display("FAIL t3_blocked[%0d]: rd=%b outst=%0d want 0/8", c, bus.o_pkt_rd, bus.ov_outstanding);
            end
        end
        drive_data(rand_data());
        tick();
        bus.i_pkt_data_wr = 1'b0;
        e = exp_q.pop_front();
        total++;
        if (bus.ov_pkt_data_wr !== e.wr || bus.ov_pkt_data !== e.data || bus.ov_outstanding !== 4'd7) begin
            bad++;
            $display("FAIL t3_data: wr=%b data=%h outst=%0d want wr=%b data=%h outst=7",
                     bus.ov_pkt_data_wr, bus.ov_pkt_data, bus.ov_outstanding, e.wr, e.data);
        end
        tick();
        total++;
        if (bus.o_pkt_rd !== 1'b1 || bus.ov_pkt_raddr !== addr_tab[2]) begin
            bad++;
            $display("FAIL t3_regrant: rd=%b addr=%h want 1/%h", bus.o_pkt_rd, bus.ov_pkt_raddr, addr_tab[2]);
        end
        bus.i_pkt_raddr_ack = 1'b1;
        tick();
        bus.i_pkt_raddr_ack = 1'b0;
        bus.iv_pkt_rd = '0;
        tag_q.push_back(2);
        total++;
        if (bus.ov_pkt_raddr_ack !== 4'b0100) begin
            bad++;
            $display("FAIL t3_regrant_ack: ack=%b want 0100", bus.ov_pkt_raddr_ack);
        end
        test_drain("t3");
    endtask

    task automatic test_simultaneous();
        exp_t e;
        bus.iv_pkt_rd = 4'b1000;
        for (int c = 0; c < 10 && bus.o_pkt_rd !== 1'b1; c++) tick();
        bus.i_pkt_raddr_ack = 1'b1;
        tick();
        bus.i_pkt_raddr_ack = 1'b0;
        bus.iv_pkt_rd = '0;
        tag_q.push_back(3);
        total++;
        if (bus.ov_pkt_raddr_ack !== 4'b1000) begin
            bad++;
            $display("FAIL t4_setup_ack: ack=%b want 1000", bus.ov_pkt_raddr_ack);
        end
        bus.iv_pkt_rd = 4'b0010;
        for (int c = 0; c < 10 && bus.o_pkt_rd !== 1'b1; c++) tick();
        total++;
        if (bus.o_pkt_rd !== 1'b1 || bus.ov_pkt_raddr !== addr_tab[1] || bus.ov_outstanding !== 4'd1) begin
            bad++;
            $display("FAIL t4_grant: rd=%b addr=%h outst=%0d want 1/%h/1",
                     bus.o_pkt_rd, bus.ov_pkt_raddr, bus.ov_outstanding, addr_tab[1]);
        end
        bus.i_pkt_raddr_ack = 1'b1;
        drive_data(rand_data());
        tick();
        bus.i_pkt_raddr_ack = 1'b0;
        bus.i_pkt_data_wr = 1'b0;
        bus.iv_pkt_rd = '0;
        tag_q.push_back(1);
        e = exp_q.pop_front();
        total++;
        if (bus.ov_pkt_data_wr !== e.wr || bus.ov_pkt_data !== e.data || bus.ov_pkt_raddr_ack !== 4'b0010 ||
            bus.ov_outstanding !== 4'd1) begin
            bad++;
            $display("FAIL t4_same_cycle: wr=%b ack=%b outst=%0d want wr=%b ack=0010 outst=1",
                     bus.ov_pkt_data_wr, bus.ov_pkt_raddr_ack, bus.ov_outstanding, e.wr);
        end
        test_drain("t4");
    endtask

    task automatic test_underflow();
        exp_t e;
        drive_data(rand_data());
        tick();
        bus.i_pkt_data_wr = 1'b0;
        e = exp_q.pop_front();
        total++;
        if (bus.ov_pkt_data_wr !== e.wr || bus.o_tag_underflow_error_pulse !== e.uf) begin
            bad++;
            $display("FAIL t5_underflow: wr=%b uf=%b want wr=%b uf=%b",
                     bus.ov_pkt_data_wr, bus.o_tag_underflow_error_pulse, e.wr, e.uf);
        end
        tick();
        total++;
        if (bus.o_tag_underflow_error_pulse !== 1'b0 || bus.ov_outstanding !== 4'd0) begin
            bad++;
            $display("FAIL t5_uf_pulse: uf=%b outst=%0d want 0/0", bus.o_tag_underflow_error_pulse, bus.ov_outstanding);
        end
    endtask

    task automatic test_reset_mid_read();
        exp_t e;
        int   p;
        bus.iv_pkt_rd = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            p = (2 + k) % 4;
            for (int c = 0; c < 10 && bus.o_pkt_rd !== 1'b1; c++) tick();
            bus.i_pkt_raddr_ack = 1'b1;
            tick();
            bus.i_pkt_raddr_ack = 1'b0;
            total++;
            if (bus.ov_pkt_raddr_ack !== (4'b0001 << p)) begin
                bad++;
                $display("FAIL t6_pre_ack[%0d]: ack=%b want %b", k, bus.ov_pkt_raddr_ack, 4'b0001 << p);
            end
        end
        for (int c = 0; c < 10 && bus.o_pkt_rd !== 1'b1; c++) tick();
        total++;
        if (bus.o_pkt_rd !== 1'b1 || bus.ov_outstanding !== 4'd3 || bus.ov_pkt_raddr !== addr_tab[1]) begin
            bad++;
            $display("FAIL t6_inflight: rd=%b outst=%0d addr=%h want 1/3/%h",
                     bus.o_pkt_rd, bus.ov_outstanding, bus.ov_pkt_raddr, addr_tab[1]);
        end
        rst = 1'b1;
        bus.iv_pkt_rd = '0;
        tick();
        rst = 1'b0;
        tag_q.delete();
        total++;
        if ({bus.o_pkt_rd, bus.ov_pkt_raddr_ack, bus.ov_pkt_data_wr, bus.o_tag_underflow_error_pulse,
             bus.ov_outstanding, bus.ov_pkt_raddr} !== 31'd0 || bus.ov_pkt_data !== '0) begin
            bad++;
            $display("FAIL t6_reset: rd=%b ack=%b wr=%b uf=%b outst=%0d addr=%h want all zero",
                     bus.o_pkt_rd, bus.ov_pkt_raddr_ack, bus.ov_pkt_data_wr,
                     bus.o_tag_underflow_error_pulse, bus.ov_outstanding, bus.ov_pkt_raddr);
        end
        drive_data(rand_data());
        tick();
        bus.i_pkt_data_wr = 1'b0;
        e = exp_q.pop_front();
        total++;
        if (bus.ov_pkt_data_wr !== e.wr || bus.o_tag_underflow_error_pulse !== e.uf) begin
            bad++;
            $display("FAIL t6_stale: wr=%b uf=%b want wr=%b uf=%b",
                     bus.ov_pkt_data_wr, bus.o_tag_underflow_error_pulse, e.wr, e.uf);
        end
        bus.iv_pkt_rd = 4'b0011;
        for (int c = 0; c < 10 && bus.o_pkt_rd !== 1'b1; c++) tick();
        total++;
        if (bus.o_pkt_rd !== 1'b1 || bus.ov_pkt_raddr !== addr_tab[0]) begin
            bad++;
            $display("FAIL t6_regrant: rd=%b addr=%h want 1/%h", bus.o_pkt_rd, bus.ov_pkt_raddr, addr_tab[0]);
        end
        bus.i_pkt_raddr_ack = 1'b1;
        tick();
        bus.i_pkt_raddr_ack = 1'b0;
        bus.iv_pkt_rd = '0;
        tag_q.push_back(0);
        total++;
        if (bus.ov_pkt_raddr_ack !== 4'b0001) begin
            bad++;
            $display("FAIL t6_ack: ack=%b want 0001", bus.ov_pkt_raddr_ack);
        end
        test_drain("t6");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        test_reset();
        test_single_port();
        test_fairness();
        test_full();
        test_simultaneous();
        test_underflow();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
